combat_resolver: RTL and testbench

- Consumer-side partner of the per-player movement controllers. Takes each player's sprite position and one-hot-ish action flags, decides whether an attack lands, and keeps health.
- Drives the `collision` input back into both movement blocks. Drives health, hit and KO status to the HUD/renderer.
- Operates once per frame on frame_clk. Round state is held in a small FSM.

---
 rtl/combat_pkg.sv | 47 ++++
 rtl/combat_resolver_attack_channel.sv | 82 ++++++++
 rtl/combat_resolver.sv | 161 ++++++++++++++++
 tb/tb_combat_resolver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/combat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : combat_pkg
// Purpose  : Shared types, winner codes and damage lookup for combat_resolver.
// Revision : 1.0 - initial release
// ============================================================================
package combat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_PAUSE = 2'd2,
        ST_KO    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ATK_NONE  = 2'd0,
        ATK_PUNCH = 2'd1,
        ATK_KICK  = 2'd2,
        ATK_SHOOT = 2'd3
    } attack_t;

    localparam logic [1:0] c_WIN_NONE = 2'b00;
    localparam logic [1:0] c_WIN_P1   = 2'b01;
    localparam logic [1:0] c_WIN_P2   = 2'b10;
    localparam logic [1:0] c_WIN_DRAW = 2'b11;

    // Blocking halves the base damage of whatever attack type landed.
    function automatic logic [6:0] damage_lookup(
        input attack_t    atk,
        input logic [6:0] punch_dmg,
        input logic [6:0] kick_dmg,
        input logic [6:0] shoot_dmg,
        input logic       blocked
    );
        logic [6:0] base;
        case (atk)
            ATK_PUNCH: base = punch_dmg;
            ATK_KICK:  base = kick_dmg;
            ATK_SHOOT: base = shoot_dmg;
            default:   base = 7'd0;
        endcase
        return blocked ? (base >> 1) : base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/combat_resolver_attack_channel.sv
`default_nettype none
// ============================================================================
// Module   : attack_channel
// Purpose  : One attacker: edge detect, priority select, cooldown, reach check.
// Revision : 1.0 - initial release
// ============================================================================
module attack_channel #(
    parameter int PUNCH_DMG   = 5,
    parameter int KICK_DMG    = 8,
    parameter int SHOOT_DMG   = 10,
    parameter int PUNCH_REACH = 140,
    parameter int KICK_REACH  = 160,
    parameter int COOLDOWN    = 20
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       fight,
    input  logic       kick,
    input  logic       punch,
    input  logic       shoot,
    input  logic       victim_block,
    input  logic       victim_crouch,
    input  logic       victim_jump,
    input  logic [9:0] dx,
    output logic       landed,
    output logic [6:0] damage
);
    import combat_pkg::*;

    localparam int c_CD_W = $clog2(COOLDOWN + 1);

    logic              r_kick_q;
    logic              r_punch_q;
    logic              r_shoot_q;
    logic [c_CD_W-1:0] r_cooldown;
    attack_t           w_atk;
    logic              w_connect;

    always_comb begin
        w_atk = ATK_NONE;
        if (fight && (r_cooldown == '0)) begin
            if (shoot && !r_shoot_q)
                w_atk = ATK_SHOOT;
            else if (kick && !r_kick_q)
                w_atk = ATK_KICK;
            else if (punch && !r_punch_q)
                w_atk = ATK_PUNCH;
        end

        case (w_atk)
            ATK_PUNCH: w_connect = (dx <= 10'(PUNCH_REACH)) && !victim_crouch;
            ATK_KICK:  w_connect = (dx <= 10'(KICK_REACH));
            ATK_SHOOT: w_connect = !victim_jump;
            default:   w_connect = 1'b0;
        endcase
    end

    assign landed = w_connect;
    assign damage = w_connect ? damage_lookup(w_atk, 7'(PUNCH_DMG), 7'(KICK_DMG),
                                              7'(SHOOT_DMG), victim_block)
                              : 7'd0;

    // Flag history tracks every frame so a press made while paused never fires later.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_kick_q   <= 1'b0;
            r_punch_q  <= 1'b0;
            r_shoot_q  <= 1'b0;
            r_cooldown <= '0;
        end else begin
            r_kick_q  <= kick;
            r_punch_q <= punch;
            r_shoot_q <= shoot;
            if (w_atk != ATK_NONE)
                r_cooldown <= c_CD_W'(COOLDOWN - 1);
            else if (fight && (r_cooldown != '0))
                r_cooldown <= r_cooldown - c_CD_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/combat_resolver.sv
`default_nettype none
// ============================================================================
// Module   : combat_resolver
// Purpose  : Per-frame hit resolution, health, invulnerability and round FSM.
// Revision : 1.0 - initial release
// ============================================================================
module combat_resolver #(
    parameter int MAX_HEALTH   = 100,
    parameter int PUNCH_DMG    = 5,
    parameter int KICK_DMG     = 8,
    parameter int SHOOT_DMG    = 10,
    parameter int PUNCH_REACH  = 140,
    parameter int KICK_REACH   = 160,
    parameter int COLLIDE_DIST = 100,
    parameter int COOLDOWN     = 20,
    parameter int INVULN       = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [9:0] SpriteX1,
    input  logic [9:0] SpriteY1,
    input  logic [9:0] SpriteX2,
    input  logic [9:0] SpriteY2,
    input  logic       kick1,
    input  logic       punch1,
    input  logic       shoot1,
    input  logic       block1,
    input  logic       crouch1,
    input  logic       jump1,
    input  logic       kick2,
    input  logic       punch2,
    input  logic       shoot2,
    input  logic       block2,
    input  logic       crouch2,
    input  logic       jump2,
    output logic       collision,
    output logic [6:0] health1,
    output logic [6:0] health2,
    output logic       hit1,
    output logic       hit2,
    output logic       game_over,
    output logic [1:0] winner
);
    import combat_pkg::*;

    localparam int c_IV_W = $clog2(INVULN + 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [c_IV_W-1:0] r_invuln1;
    logic [c_IV_W-1:0] r_invuln2;
    logic [9:0]        w_dx;
    logic              w_fight;
    logic              w_ch1_landed;
    logic              w_ch2_landed;
    logic [6:0]        w_dmg1;
    logic [6:0]        w_dmg2;
    logic              w_land1;
    logic              w_land2;
    logic [6:0]        w_hp1_next;
    logic [6:0]        w_hp2_next;
    logic              w_ko;
    logic              w_unused_y;

    assign w_unused_y = ^{SpriteY1, SpriteY2};
    assign w_dx       = (SpriteX1 >= SpriteX2) ? (SpriteX1 - SpriteX2) : (SpriteX2 - SpriteX1);
    assign w_fight    = (r_state == ST_FIGHT);

    attack_channel #(
        .PUNCH_DMG(PUNCH_DMG), .KICK_DMG(KICK_DMG), .SHOOT_DMG(SHOOT_DMG),
        .PUNCH_REACH(PUNCH_REACH), .KICK_REACH(KICK_REACH), .COOLDOWN(COOLDOWN)
    ) u_ch1 (
        .frame_clk(frame_clk), .Reset(Reset), .fight(w_fight),
        .kick(kick1), .punch(punch1), .shoot(shoot1),
        .victim_block(block2), .victim_crouch(crouch2), .victim_jump(jump2),
        .dx(w_dx), .landed(w_ch1_landed), .damage(w_dmg2)
    );

    attack_channel #(
        .PUNCH_DMG(PUNCH_DMG), .KICK_DMG(KICK_DMG), .SHOOT_DMG(SHOOT_DMG),
        .PUNCH_REACH(PUNCH_REACH), .KICK_REACH(KICK_REACH), .COOLDOWN(COOLDOWN)
    ) u_ch2 (
        .frame_clk(frame_clk), .Reset(Reset), .fight(w_fight),
        .kick(kick2), .punch(punch2), .shoot(shoot2),
        .victim_block(block1), .victim_crouch(crouch1), .victim_jump(jump1),
        .dx(w_dx), .landed(w_ch2_landed), .damage(w_dmg1)
    );

    // An invulnerable victim swallows the attack; the attacker's cooldown still runs.
    assign w_land1    = w_ch2_landed && (r_invuln1 == '0);
    assign w_land2    = w_ch1_landed && (r_invuln2 == '0);
    assign w_hp1_next = !w_land1 ? health1 : ((health1 > w_dmg1) ? (health1 - w_dmg1) : 7'd0);
    assign w_hp2_next = !w_land2 ? health2 : ((health2 > w_dmg2) ? (health2 - w_dmg2) : 7'd0);
    assign w_ko       = w_fight && ((w_hp1_next == 7'd0) || (w_hp2_next == 7'd0));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_FIGHT;
            ST_FIGHT: begin
                if (w_ko)
                    w_state_next = ST_KO;
                else if (!start)
                    w_state_next = ST_PAUSE;
            end
            ST_PAUSE: if (start) w_state_next = ST_FIGHT;
            default:  w_state_next = r_state;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            collision <= 1'b0;
            health1   <= 7'(MAX_HEALTH);
            health2   <= 7'(MAX_HEALTH);
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            game_over <= 1'b0;
            winner    <= c_WIN_NONE;
            r_invuln1 <= '0;
            r_invuln2 <= '0;
        end else begin
            if (r_state != ST_KO)
                collision <= (w_dx < 10'(COLLIDE_DIST));
            hit1    <= w_land1;
            hit2    <= w_land2;
            health1 <= w_hp1_next;
            health2 <= w_hp2_next;

            if (w_land1)
                r_invuln1 <= c_IV_W'(INVULN - 1);
            else if (w_fight && (r_invuln1 != '0))
                r_invuln1 <= r_invuln1 - c_IV_W'(1);

            if (w_land2)
                r_invuln2 <= c_IV_W'(INVULN - 1);
            else if (w_fight && (r_invuln2 != '0))
                r_invuln2 <= r_invuln2 - c_IV_W'(1);

            if (w_ko) begin
                game_over <= 1'b1;
                if ((w_hp1_next == 7'd0) && (w_hp2_next == 7'd0))
                    winner <= c_WIN_DRAW;
                else if (w_hp1_next == 7'd0)
                    winner <= c_WIN_P2;
                else
                    winner <= c_WIN_P1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_combat_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_combat_resolver
// Purpose  : Scoreboard bench for combat_resolver against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combat_resolver;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [9:0] SpriteX1 = '0, SpriteY1 = '0, SpriteX2 = '0, SpriteY2 = '0;
    logic       kick1 = 0, punch1 = 0, shoot1 = 0, block1 = 0, crouch1 = 0, jump1 = 0;
    logic       kick2 = 0, punch2 = 0, shoot2 = 0, block2 = 0, crouch2 = 0, jump2 = 0;
    logic       collision;
    logic [6:0] health1, health2;
    logic       hit1, hit2, game_over;
    logic [1:0] winner;

    combat_resolver dut (
        .frame_clk(frame_clk), .Reset(Reset), .start(start),
        .SpriteX1(SpriteX1), .SpriteY1(SpriteY1), .SpriteX2(SpriteX2), .SpriteY2(SpriteY2),
        .kick1(kick1), .punch1(punch1), .shoot1(shoot1),
        .block1(block1), .crouch1(crouch1), .jump1(jump1),
        .kick2(kick2), .punch2(punch2), .shoot2(shoot2),
        .block2(block2), .crouch2(crouch2), .jump2(jump2),
        .collision(collision), .health1(health1), .health2(health2),
        .hit1(hit1), .hit2(hit2), .game_over(game_over), .winner(winner)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int col; int hp1; int hp2; int h1; int h2; int over; int win;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   armed = 0;
    event sample_ev;

    // Reference model: mode 0 idle, 1 fighting, 2 paused, 3 knocked out.
    int m_mode;
    int m_hp[2], m_cd[2], m_inv[2], m_hit[2];
    int m_prev[2][3];
    int m_col, m_over, m_win;
    int DMG[3]   = '{5, 8, 10};

    task automatic check(input string name, input logic [31:0] act, input int req);
        total++;
        if (act !== 32'(req)) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        int fl[2][6];
        int landed[2], dmg[2];
        int d, x1, x2, v, kind, ok;
        exp_t e;
        fl[0][0] = int'(punch1); fl[0][1] = int'(kick1); fl[0][2] = int'(shoot1);
        fl[0][3] = int'(block1); fl[0][4] = int'(crouch1); fl[0][5] = int'(jump1);
        fl[1][0] = int'(punch2); fl[1][1] = int'(kick2); fl[1][2] = int'(shoot2);
        fl[1][3] = int'(block2); fl[1][4] = int'(crouch2); fl[1][5] = int'(jump2);
        if (Reset) begin
            m_mode = 0; m_col = 0; m_over = 0; m_win = 0;
            for (int p = 0; p < 2; p++) begin
                m_hp[p] = 100; m_cd[p] = 0; m_inv[p] = 0; m_hit[p] = 0;
                for (int k = 0; k < 3; k++) m_prev[p][k] = 0;
            end
        end else begin
            x1 = int'(SpriteX1); x2 = int'(SpriteX2);
            d  = (x1 > x2) ? x1 - x2 : x2 - x1;
            if (m_mode != 3) m_col = (d < 100) ? 1 : 0;
            m_hit[0] = 0; m_hit[1] = 0;
            if (m_mode == 1) begin
                landed[0] = 0; landed[1] = 0; dmg[0] = 0; dmg[1] = 0;
                for (int a = 0; a < 2; a++) begin
                    v = 1 - a;
                    if (m_cd[a] > 0) m_cd[a]--;
                    else begin
                        kind = -1;
                        for (int k = 0; k < 3; k++)
                            if (fl[a][k] == 1 && m_prev[a][k] == 0) kind = k;
                        if (kind >= 0) begin
                            m_cd[a] = 19;
                            if (kind == 0)      ok = (d <= 140 && fl[v][4] == 0) ? 1 : 0;
                            else if (kind == 1) ok = (d <= 160) ? 1 : 0;
                            else                ok = (fl[v][5] == 0) ? 1 : 0;
                            if (ok == 1 && m_inv[v] == 0) begin
                                landed[v] = 1;
                                dmg[v] = (fl[v][3] == 1) ? DMG[kind] / 2 : DMG[kind];
                            end
                        end
                    end
                end
                for (int p = 0; p < 2; p++) begin
                    if (landed[p] == 1) begin
                        m_hp[p]  = (m_hp[p] > dmg[p]) ? m_hp[p] - dmg[p] : 0;
                        m_hit[p] = 1;
                        m_inv[p] = 29;
                    end else if (m_inv[p] > 0) m_inv[p]--;
                end
                if (m_hp[0] == 0 || m_hp[1] == 0) begin
                    m_mode = 3; m_over = 1;
                    m_win = (m_hp[0] == 0 && m_hp[1] == 0) ? 3 : (m_hp[0] == 0) ? 2 : 1;
                end else if (!start) m_mode = 2;
            end else if (m_mode != 3 && start) m_mode = 1;
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 3; k++) m_prev[p][k] = fl[p][k];
        end
        e.col = m_col; e.hp1 = m_hp[0]; e.hp2 = m_hp[1];
        e.h1 = m_hit[0]; e.h2 = m_hit[1]; e.over = m_over; e.win = m_win;
        q.push_back(e);
    endtask

    task automatic step();
        model_step();
        armed = 1;
        @(negedge frame_clk);
    endtask

    task automatic frames(input int n);
        repeat (n) step();
    endtask

    task automatic clr_flags();
        {kick1, punch1, shoot1, block1, crouch1, jump1} = '0;
        {kick2, punch2, shoot2, block2, crouch2, jump2} = '0;
    endtask

    task automatic new_round(input int x1, input int x2);
        Reset = 1; start = 0; clr_flags();
        SpriteX1 = 10'(x1); SpriteX2 = 10'(x2);
        step();
        Reset = 0; start = 1;
        step();
    endtask

    task automatic reach_probe(input int dxv, input int use_kick);
        new_round(100, 100 + dxv);
        if (use_kick == 1) kick1 = 1; else punch1 = 1;
        step(); clr_flags(); step();
    endtask

    task automatic invuln_probe(input int off);
        new_round(200, 300);
        punch1 = 1; step(); punch1 = 0;
        frames(off - 1);
        kick1 = 1; step(); kick1 = 0; step();
    endtask

    initial begin
        forever begin
            @(posedge frame_clk);
            #1;
            if (armed) -> sample_ev;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
            end else begin
                e = q.pop_front();
                check("collision", 32'(collision), e.col);
                check("health1",   32'(health1),   e.hp1);
                check("health2",   32'(health2),   e.hp2);
                check("hit1",      32'(hit1),      e.h1);
                check("hit2",      32'(hit2),      e.h2);
                check("game_over", 32'(game_over), e.over);
                check("winner",    32'(winner),    e.win);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int x;
        @(negedge frame_clk);
        step(); step();

        // Clean punch at dx=100, then cooldown and invulnerability lockouts.
        new_round(200, 300);
        punch1 = 1; step(); punch1 = 0;
        frames(4);
        punch1 = 1; step(); punch1 = 0;
        frames(15);
        kick1 = 1; step(); kick1 = 0;
        frames(19);
        kick1 = 1; step(); kick1 = 0;
        frames(3);

        // Dodged punch, then blocked kick.
        new_round(200, 330);
        crouch2 = 1; punch1 = 1; step(); punch1 = 0; crouch2 = 0;
        frames(19);
        block2 = 1; kick1 = 1; step(); kick1 = 0; block2 = 0;
        frames(2);

        reach_probe(140, 0); reach_probe(141, 0);
        reach_probe(160, 1); reach_probe(161, 1);
        invuln_probe(29); invuln_probe(30);

        // Pause freezes cooldown; a press during pause stays silent on resume.
        new_round(200, 300);
        kick1 = 1; step(); kick1 = 0;
        frames(6);
        start = 0; frames(4);
        shoot1 = 1; kick2 = 1; frames(6);
        start = 1; frames(15);
        shoot1 = 0; kick2 = 0; step();
        shoot1 = 1; step(); shoot1 = 0; frames(3);

        // One-sided fight to a P1 win.
        new_round(300, 700);
        for (int i = 0; i < 30 && m_mode != 3; i++) begin
            block2 = 1'($urandom_range(0, 1));
            shoot1 = 1; step(); shoot1 = 0; block2 = 0;
            frames(29);
        end
        frames(2);

        // Simultaneous volleys drive both to zero: draw, then frozen, then async reset.
        new_round(200, 250);
        for (int i = 0; i < 12 && m_mode != 3; i++) begin
            shoot1 = 1; shoot2 = 1; step(); shoot1 = 0; shoot2 = 0;
            frames(29);
        end
        start = 0; frames(3); start = 1; punch2 = 1; frames(3); punch2 = 0; frames(2);
        Reset = 1;
        #1;
        model_step();
        -> sample_ev;
        model_step();
        @(negedge frame_clk);
        Reset = 0; start = 0; step();

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 699) == 0);
            start = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 7) == 0) begin
                x = int'($urandom_range(0, 1023));
                SpriteX1 = 10'(x);
                SpriteX2 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                        : 10'((x + int'($urandom_range(0, 200))) % 1024);
            end
            punch1 = ($urandom_range(0, 5) == 0); kick1 = ($urandom_range(0, 7) == 0);
            shoot1 = ($urandom_range(0, 9) == 0); block1 = ($urandom_range(0, 2) == 0);
            crouch1 = ($urandom_range(0, 3) == 0); jump1 = ($urandom_range(0, 3) == 0);
            punch2 = ($urandom_range(0, 5) == 0); kick2 = ($urandom_range(0, 7) == 0);
            shoot2 = ($urandom_range(0, 9) == 0); block2 = ($urandom_range(0, 2) == 0);
            crouch2 = ($urandom_range(0, 3) == 0); jump2 = ($urandom_range(0, 3) == 0);
            step();
        end

        clr_flags(); Reset = 0;
        step();
        armed = 0;
        #20;
        check("scoreboard_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
